des8_align: RTL and testbench
=============================

# des8_align

Soft 1:8 serial deserializer with bit-slip word alignment and an optional training-pattern aligner. It is the receive-side counterpart of the OSER8 serializer test path: it samples a serial lane once per `clk_i`, assembles 8-bit words (first received bit in bit 0, matching D0 transmitted first), and emits them with a strobe and a divided word clock. It sits between a board input pin (or the OSER8 `Q0` loopback) and the logic-analyzer / LED checking logic.

## Interface
- `TRAIN_PATTERN`, 8'hAA: word expected during alignment (serial stream 0,1,0,1,…).
- `SETTLE_WORDS`, 2: words discarded after each slip before comparing again (1–15).
- `MATCH_WORDS`, 4: consecutive matching words required for lock (1–15).
- `clk_i`  in  1  single bit-rate clock; all logic on its rising edge.
- `nrst_i`  in  1  asynchronous active-low reset.
- `d_i`  in  1  serial data, one bit per `clk_i`.
- `calib_i`  in  1  manual bit-slip request; rising edge = one slip.
- `align_en_i`  in  1  enable auto-alignment (macro-dependent).
- `q_o`  out  8  last completed word; `q_o[0]` = earliest bit.
- `valid_o`  out  1  one-cycle strobe, `q_o` updated this cycle.
- `pclk_o`  out  1  word-rate clock, fclk/8, 50% duty.
- `lock_o`  out  1  aligner locked.
- `fail_o`  out  1  sticky: 8 slips done without lock.

## Operation
- Shift register `sr[7:0]` shifts every cycle: `sr <= {d_i, sr[7:1]}`.
- Phase counter `cnt` 0..7 increments every cycle, wraps 7→0.
- When `cnt==7`: next cycle `q_o <= {d_i, sr[7:1]}`, `valid_o=1`.
- Slip: `calib_i` registered once, rising edge detected → slip cycle one cycle after edge. In a slip cycle `cnt` holds (no increment); `sr` still shifts. Word boundary moves one bit later. Slip in a `cnt==7` cycle suppresses that word; it completes one cycle later.
- Back-to-back `calib_i` edges: each edge one slip; `calib_i` held high = one slip.
- `pclk_o` = 1 when `cnt` in 4..7, else 0.
- Aligner FSM (macro-enabled): IDLE, HUNT, SETTLE, LOCKED.
  - IDLE: `align_en_i`=0; manual slips honored. `align_en_i`=1 → HUNT, clear match/slip counters, clear `fail_o`.
  - HUNT: on each word, match → `match_cnt++`; reaching `MATCH_WORDS` → LOCKED. Mismatch → clear `match_cnt`, internal slip, `slip_cnt++`, → SETTLE.
  - SETTLE: count `SETTLE_WORDS` words, then HUNT.
  - `slip_cnt` reaching 8 → `fail_o=1` (sticky), counter wraps, hunting continues.
  - LOCKED: `lock_o=1`, no further comparison; payload arbitrary.
  - `align_en_i`=0 in any state → IDLE next cycle, `lock_o=0`; `fail_o` holds until next HUNT entry.
  - `calib_i` ignored in HUNT/SETTLE/LOCKED.

## Timing
- Reset (async assert, sync to next edge on release): `sr`=0, `cnt`=0, `q_o`=8'h00, `valid_o`=0, `pclk_o`=0, `lock_o`=0, `fail_o`=0, FSM=IDLE, edge register=0.
- Bit on `d_i` at `cnt==7` edge → visible in `q_o` one cycle later (latency 1 after last bit, 8 after first).
- `valid_o` period exactly 8 cycles without slips; 9 across one slip.
- `calib_i` edge → slip 1 cycle later (register + detect).
- Reset mid-word: partial word discarded, no `valid_o`.

## Configuration
- `DES8_AUTOALIGN_EN` defined: aligner FSM present as above.
- Undefined: no FSM; `calib_i` always honored; `align_en_i` unused; `lock_o`, `fail_o` tied 0; parameters `TRAIN_PATTERN`/`SETTLE_WORDS`/`MATCH_WORDS` unused.

## Structure
- Shared package `des8_pkg`: FSM state enum, `WORD_W`=8, slip-limit constant 8.
- Sub-module `des8_aligner`: FSM + counters; inputs word/valid, outputs slip request, lock, fail. Top instantiates it only under the macro.

## Test plan
- Reset: hold `nrst_i`=0 with toggling `d_i` → all outputs 0; release → first `valid_o` 8 cycles later.
- Stream 0,1,0,1… aligned at reset → `q_o`=8'hAA every 8 cycles, `pclk_o` 4 high/4 low.
- Stream 8'h3C repeating, pulse `calib_i` once → one 9-cycle `valid_o` gap, then `q_o`=8'h1E (rotated one bit); repeated for 8 pulses returns to 8'h3C.
- Macro on, stream offset one bit from 8'hAA (reads 8'h55), `align_en_i`=1 → one slip, `lock_o`=1 after `SETTLE_WORDS`+`MATCH_WORDS` words, `q_o`=8'hAA.
- Macro on, constant 8'hFF stream → `fail_o`=1 after 8th slip, `lock_o`=0; drop `align_en_i` → FSM IDLE, `fail_o` stays 1 until re-enable.
- Assert `nrst_i`=0 mid-HUNT → `lock_o`/`fail_o` 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/des8_pkg.sv
// Shared types and constants for the des8_align deserializer and its aligner.
// Shared by both builds; only the aligner uses the state type (DES8_AUTOALIGN_EN).
package des8_pkg;
    localparam int WORD_W     = 8;
    localparam int CNT_W      = $clog2(WORD_W);
    localparam int SLIP_LIMIT = 8;
    localparam int SLIP_CNT_W = $clog2(SLIP_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_SETTLE,
        ST_LOCKED
    } align_state_t;
endpackage

// File: rtl/des8_aligner.sv
// Training-pattern aligner: hunts for TRAIN_PATTERN, requests bit slips on
// mismatch, and reports lock or a sticky failure after a full slip rotation.
module des8_aligner
    import des8_pkg::*;
#(
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'hAA,
    parameter int                SETTLE_WORDS  = 2,
    parameter int                MATCH_WORDS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WORD_W-1:0] word,
    input  logic              word_valid,
    output logic              slip,
    output logic              idle,
    output logic              lock,
    output logic              fail
);
    localparam logic [3:0] MATCH_LAST  = 4'(MATCH_WORDS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_WORDS - 1);
    localparam logic [SLIP_CNT_W-1:0] SLIPS_LAST = SLIP_CNT_W'(SLIP_LIMIT - 1);

    align_state_t            state_reg, state_next;
    logic [3:0]              match_reg, match_next;
    logic [3:0]              settle_reg, settle_next;
    logic [SLIP_CNT_W-1:0]   slips_reg, slips_next;
    logic                    fail_reg, fail_next;
    logic                    slip_reg, slip_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            match_reg  <= '0;
            settle_reg <= '0;
            slips_reg  <= '0;
            fail_reg   <= 1'b0;
            slip_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            match_reg  <= match_next;
            settle_reg <= settle_next;
            slips_reg  <= slips_next;
            fail_reg   <= fail_next;
            slip_reg   <= slip_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        match_next  = match_reg;
        settle_next = settle_reg;
        slips_next  = slips_reg;
        fail_next   = fail_reg;
        slip_next   = 1'b0;
        if (!en) begin
            // fail is left untouched here so it stays visible while disabled
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    state_next  = ST_HUNT;
                    match_next  = '0;
                    settle_next = '0;
                    slips_next  = '0;
                    fail_next   = 1'b0;
                end
                ST_HUNT: begin
                    if (word_valid) begin
                        if (word == TRAIN_PATTERN) begin
                            if (match_reg == MATCH_LAST) state_next = ST_LOCKED;
                            else                         match_next = match_reg + 4'd1;
                        end else begin
                            match_next  = '0;
                            settle_next = '0;
                            slip_next   = 1'b1;
                            slips_next  = slips_reg + 1'b1;
                            if (slips_reg == SLIPS_LAST) fail_next = 1'b1;
                            state_next  = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (word_valid) begin
                        if (settle_reg == SETTLE_LAST) begin
                            settle_next = '0;
                            state_next  = ST_HUNT;
                        end else begin
                            settle_next = settle_reg + 4'd1;
                        end
                    end
                end
                ST_LOCKED: state_next = ST_LOCKED;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    assign slip = slip_reg;
    assign idle = (state_reg == ST_IDLE);
    assign lock = (state_reg == ST_LOCKED);
    assign fail = fail_reg;
endmodule

// File: rtl/des8_align.sv
// Soft 1:8 deserializer with bit-slip alignment; first received bit lands in q_o[0].
// Define DES8_AUTOALIGN_EN to include the training-pattern aligner.
module des8_align
    import des8_pkg::*;
#(
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'hAA,
    parameter int                SETTLE_WORDS  = 2,
    parameter int                MATCH_WORDS   = 4
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              d_i,
    input  logic              calib_i,
    input  logic              align_en_i,
    output logic [WORD_W-1:0] q_o,
    output logic              valid_o,
    output logic              pclk_o,
    output logic              lock_o,
    output logic              fail_o
);
    logic [WORD_W-1:0] sr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              calib_reg;
    logic              edge_reg;
    logic              slip;
    logic              word_done;

`ifdef DES8_AUTOALIGN_EN
    logic auto_slip;
    logic aligner_idle;

    des8_aligner #(
        .TRAIN_PATTERN (TRAIN_PATTERN),
        .SETTLE_WORDS  (SETTLE_WORDS),
        .MATCH_WORDS   (MATCH_WORDS)
    ) u_aligner (
        .clk        (clk_i),
        .rst_n      (nrst_i),
        .en         (align_en_i),
        .word       (q_o),
        .word_valid (valid_o),
        .slip       (auto_slip),
        .idle       (aligner_idle),
        .lock       (lock_o),
        .fail       (fail_o)
    );

    // Manual slips only count while the aligner is not driving the boundary
    assign slip = (edge_reg & aligner_idle) | auto_slip;
`else
    logic unused_cfg;

    assign unused_cfg = ^{align_en_i, TRAIN_PATTERN, SETTLE_WORDS[3:0], MATCH_WORDS[3:0]};
    assign slip       = edge_reg;
    assign lock_o     = 1'b0;
    assign fail_o     = 1'b0;
`endif

    // A slip cycle freezes the phase counter, pushing the boundary one bit later
    assign word_done = (cnt_reg == CNT_W'(WORD_W - 1)) && !slip;
    assign pclk_o    = cnt_reg[CNT_W-1];

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sr_reg    <= '0;
            cnt_reg   <= '0;
            calib_reg <= 1'b0;
            edge_reg  <= 1'b0;
            q_o       <= '0;
            valid_o   <= 1'b0;
        end else begin
            sr_reg    <= {d_i, sr_reg[WORD_W-1:1]};
            calib_reg <= calib_i;
            edge_reg  <= calib_i & ~calib_reg;
            if (!slip) cnt_reg <= cnt_reg + 1'b1;
            valid_o   <= word_done;
            if (word_done) q_o <= {d_i, sr_reg[WORD_W-1:1]};
        end
    end
endmodule

// File: tb/tb_des8_align.sv
// Randomized self-checking bench for des8_align; the aligner scenarios run
// only when DES8_AUTOALIGN_EN is defined.
module tb_des8_align;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       d = 1'b0;
    logic       calib = 1'b0;
    logic       align_en = 1'b0;
    logic [7:0] q;
    logic       valid;
    logic       pclk;
    logic       lock;
    logic       fail;

    int checks = 0;
    int errors = 0;

    des8_align dut (
        .clk_i      (clk),
        .nrst_i     (nrst),
        .d_i        (d),
        .calib_i    (calib),
        .align_en_i (align_en),
        .q_o        (q),
        .valid_o    (valid),
        .pclk_o     (pclk),
        .lock_o     (lock),
        .fail_o     (fail)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: bit history since reset and the index of the next word's last bit
    bit         hist[$];
    int         idx;
    int         bnd;
    int         slip_at;
    bit         cal_prev;
    bit         have_exp;
    bit         exp_valid;
    bit         exp_pclk;
    logic [7:0] exp_q;

    task automatic model_reset();
        hist.delete();
        idx      = 0;
        bnd      = 7;
        slip_at  = -1;
        cal_prev = 1'b0;
        have_exp = 1'b0;
    endtask

    // Called at a falling edge: check the previous rising edge, then drive the next bit
    task automatic step(input bit dbit, input bit cbit);
        if (have_exp) begin
            check_eq("valid", valid, exp_valid);
            check_eq("pclk", pclk, exp_pclk);
            if (exp_valid) begin
                check_eq("q", q, exp_q);
                check_eq("lock_off", lock, 1'b0);
                check_eq("fail_off", fail, 1'b0);
            end
        end
        d     = dbit;
        calib = cbit;
        hist.push_back(dbit);
        if (slip_at == idx) bnd++;
        if (cbit && !cal_prev) slip_at = idx + 1;
        cal_prev  = cbit;
        exp_valid = (idx == bnd);
        if (exp_valid) begin
            for (int k = 0; k < 8; k++) exp_q[k] = hist[idx - 7 + k];
            bnd += 8;
        end
        exp_pclk = ((bnd - idx - 1) <= 3);
        have_exp = 1'b1;
        idx++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        nrst  = 1'b0;
        calib = 1'b0;
        #1;
        check_eq("rst_q", q, 8'h00);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_pclk", pclk, 1'b0);
        check_eq("rst_lock", lock, 1'b0);
        check_eq("rst_fail", fail, 1'b0);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            d = ~d;
            check_eq("rst_hold_valid", valid, 1'b0);
            check_eq("rst_hold_q", q, 8'h00);
        end
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
    endtask

    logic [7:0] pat;

    initial begin
        model_reset();
        do_reset(5);

        // Alternating stream aligned at reset reads 8'hAA
        for (int i = 0; i < 40; i++) step(bit'(idx & 1), 1'b0);
        check_eq("aa_word", q, 8'hAA);

        // 8'h3C stream: each calib pulse rotates the word by one bit
        do_reset(3);
        pat = 8'h3C;
        for (int p = 1; p <= 8; p++) begin
            step(pat[idx % 8], 1'b1);
            for (int i = 0; i < 31; i++) step(pat[idx % 8], 1'b0);
            if (p == 1) check_eq("rot1_word", q, 8'h1E);
            if (p == 8) check_eq("rot8_word", q, 8'h3C);
        end

        // Random data with random calib (held-high runs and back-to-back edges)
        do_reset(2);
        for (int i = 0; i < 300; i++)
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);

        // Reset mid-word, then resume
        for (int i = 0; i < 13; i++) step(bit'($urandom_range(0, 1)), 1'b0);
        do_reset(2);
        for (int i = 0; i < 60; i++)
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);

`ifdef DES8_AUTOALIGN_EN
        begin
            int n;
            // Stream offset by one bit: reads 8'h55 until the aligner slips once
            do_reset(2);
            n = 0;
            for (int i = 0; i < 16; i++) begin
                d = bit'((n + 1) & 1);
                n++;
                @(negedge clk);
            end
            check_eq("offset_word", q, 8'h55);
            check_eq("offset_nolock", lock, 1'b0);
            align_en = 1'b1;
            for (int k = 0; k < 400 && !lock; k++) begin
                d = bit'((n + 1) & 1);
                n++;
                @(negedge clk);
            end
            check_eq("lock_reached", lock, 1'b1);
            for (int k = 0; k < 20 && !valid; k++) begin
                d = bit'((n + 1) & 1);
                n++;
                @(negedge clk);
            end
            check_eq("locked_valid", valid, 1'b1);
            check_eq("locked_word", q, 8'hAA);

            // Disable drops lock; constant 8'hFF never matches
            align_en = 1'b0;
            d = 1'b1;
            repeat (3) @(negedge clk);
            check_eq("lock_drop", lock, 1'b0);
            align_en = 1'b1;
            for (int k = 0; k < 1500 && !fail; k++) @(negedge clk);
            check_eq("ff_fail", fail, 1'b1);
            check_eq("ff_nolock", lock, 1'b0);
            align_en = 1'b0;
            repeat (20) @(negedge clk);
            check_eq("fail_sticky", fail, 1'b1);
            check_eq("idle_nolock", lock, 1'b0);
            align_en = 1'b1;
            repeat (3) @(negedge clk);
            check_eq("fail_cleared", fail, 1'b0);

            // Reset while hunting clears status immediately
            for (int k = 0; k < 1500 && !fail; k++) @(negedge clk);
            check_eq("ff_fail_again", fail, 1'b1);
            nrst = 1'b0;
            #1;
            check_eq("hunt_rst_fail", fail, 1'b0);
            check_eq("hunt_rst_lock", lock, 1'b0);
            align_en = 1'b0;
            @(negedge clk);
            nrst = 1'b1;
            repeat (4) @(negedge clk);
            check_eq("post_rst_lock", lock, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
